upsp_wdata_packer: RTL and testbench

//   Parametrised output stage between the bicubic upsampling core and the access controller (AC) write port.

---
 rtl/upsp_wdata_packer_pkg.sv | 30 +++
 rtl/upsp_sync_fifo.sv | 47 ++++
 rtl/upsp_wdata_packer.sv | 138 +++++++++++++
 tb/tb_upsp_wdata_packer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upsp_wdata_packer_pkg.sv
// Shared helpers for the upsampler write-data packer: derived widths,
// the legal lane-count check and the FIFO entry layout {last, strb, data}.
package upsp_wdata_packer_pkg;

    function automatic bit ppb_legal(input int ppb);
        return (ppb == 1) || (ppb == 2) || (ppb == 4) || (ppb == 8) || (ppb == 16);
    endfunction

    // lane counter needs at least one bit even with a single lane
    function automatic int lane_w_f(input int ppb);
        return (ppb > 1) ? $clog2(ppb) : 1;
    endfunction

    function automatic int col_w_f(input int line_pix);
        return (line_pix > 1) ? $clog2(line_pix) : 1;
    endfunction

    function automatic int strb_lsb_f(input int pix_w, input int ppb);
        return pix_w * ppb;
    endfunction

    function automatic int last_bit_f(input int pix_w, input int ppb);
        return pix_w * ppb + ppb;
    endfunction

    function automatic int entry_w_f(input int pix_w, input int ppb);
        return pix_w * ppb + ppb + 1;
    endfunction

endpackage

// File: rtl/upsp_sync_fifo.sv
// Single-clock beat FIFO. Storage is registers; the head entry is read from
// storage and forced to zero while empty. A pop never makes room for a push
// in the same cycle.
module upsp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // pointer update; wrap bit distinguishes full from empty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // storage write; contents are don't-care until pointed at by a valid entry
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/upsp_wdata_packer.sv
// Packs one upsampled pixel per handshake into PIX_PER_BEAT-lane write beats
// for the access controller, flushing a strobed partial beat with wlast at
// every line end.
// Optional: define UPSP_PACK_STAT_EN to add the stat_beats / stat_stalls
// saturating counters; the datapath is identical either way.
module upsp_wdata_packer
    import upsp_wdata_packer_pkg::*;
#(
    parameter int PIX_W        = 24,
    parameter int PIX_PER_BEAT = 4,
    parameter int LINE_PIX     = 2560,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PIX_W-1:0]              in_pix_data,
    input  logic                          in_pix_valid,
    output logic                          in_pix_ready,
    output logic [PIX_W*PIX_PER_BEAT-1:0] upsp_ac_wdata,
    output logic [PIX_PER_BEAT-1:0]       upsp_ac_wstrb,
    output logic                          upsp_ac_wlast,
    output logic                          upsp_ac_wvalid,
    input  logic                          ac_upsp_wready
`ifdef UPSP_PACK_STAT_EN
    ,
    output logic [31:0]                   stat_beats,
    output logic [31:0]                   stat_stalls
`endif
);
    localparam int LANE_W   = lane_w_f(PIX_PER_BEAT);
    localparam int COL_W    = col_w_f(LINE_PIX);
    localparam int BEAT_W   = PIX_W * PIX_PER_BEAT;
    localparam int ENTRY_W  = entry_w_f(PIX_W, PIX_PER_BEAT);
    localparam int STRB_LSB = strb_lsb_f(PIX_W, PIX_PER_BEAT);
    localparam int LAST_BIT = last_bit_f(PIX_W, PIX_PER_BEAT);

    if (!ppb_legal(PIX_PER_BEAT)) begin : g_bad_ppb
        $error("upsp_wdata_packer: PIX_PER_BEAT must be 1, 2, 4, 8 or 16");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("upsp_wdata_packer: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    logic [LANE_W-1:0]       lane_cnt;
    logic [COL_W-1:0]        col_cnt;
    logic [BEAT_W-1:0]       asm_data;
    logic                    ready_en;
    logic                    lane_end;
    logic                    col_end;
    logic                    completing_next;
    logic                    accept;
    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [BEAT_W-1:0]       beat_data;
    logic [PIX_PER_BEAT-1:0] beat_strb;
    logic [ENTRY_W-1:0]      push_entry;
    logic [ENTRY_W-1:0]      head_entry;

    // ready only looks at counters and the full flag, never at in_pix_valid
    assign lane_end        = (lane_cnt == LANE_W'(PIX_PER_BEAT - 1));
    assign col_end         = (col_cnt == COL_W'(LINE_PIX - 1));
    assign completing_next = lane_end || col_end;
    assign in_pix_ready    = ready_en && !(completing_next && fifo_full);
    assign accept          = in_pix_valid && in_pix_ready;
    assign push            = accept && completing_next;

    // beat as it would look with the incoming pixel placed in the current lane
    always_comb begin
        beat_data = asm_data;
        beat_strb = '0;
        for (int i = 0; i < PIX_PER_BEAT; i++) begin
            if (LANE_W'(i) == lane_cnt) beat_data[i*PIX_W +: PIX_W] = in_pix_data;
            beat_strb[i] = (LANE_W'(i) <= lane_cnt);
        end
    end

    assign push_entry = {col_end, beat_strb, beat_data};

    // lane/column counters and assembly register; cleared after every push
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_cnt <= '0;
            col_cnt  <= '0;
            asm_data <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                if (completing_next) begin
                    lane_cnt <= '0;
                    asm_data <= '0;
                end else begin
                    lane_cnt <= lane_cnt + LANE_W'(1);
                    asm_data <= beat_data;
                end
                col_cnt <= col_end ? '0 : col_cnt + COL_W'(1);
            end
        end
    end

    upsp_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign upsp_ac_wvalid = !fifo_empty;
    assign pop            = upsp_ac_wvalid && ac_upsp_wready;
    assign upsp_ac_wdata  = head_entry[BEAT_W-1:0];
    assign upsp_ac_wstrb  = head_entry[STRB_LSB +: PIX_PER_BEAT];
    assign upsp_ac_wlast  = head_entry[LAST_BIT];

`ifdef UPSP_PACK_STAT_EN
    // saturating counts of accepted beats and back-pressured cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_beats  <= '0;
            stat_stalls <= '0;
        end else begin
            if (pop && (stat_beats != 32'hFFFF_FFFF))
                stat_beats <= stat_beats + 32'd1;
            if (upsp_ac_wvalid && !ac_upsp_wready && (stat_stalls != 32'hFFFF_FFFF))
                stat_stalls <= stat_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_upsp_wdata_packer.sv
// Scoreboard bench for upsp_wdata_packer. Each generated line is chunked into
// expected beats when it is issued; a negedge monitor pops and compares every
// beat the DUT hands over. Optional UPSP_PACK_STAT_EN adds statistic checks.
module tb_upsp_wdata_packer;
    localparam int PIX_W    = 24;
    localparam int PPB      = 4;
    localparam int LINE_PIX = 10;
    localparam int DEPTH    = 4;
    localparam int BEAT_W   = PIX_W * PPB;

    typedef struct packed {
        logic              last;
        logic [PPB-1:0]    strb;
        logic [BEAT_W-1:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [PIX_W-1:0]  in_pix_data = '0;
    logic              in_pix_valid = 1'b0;
    logic              in_pix_ready;
    logic [BEAT_W-1:0] upsp_ac_wdata;
    logic [PPB-1:0]    upsp_ac_wstrb;
    logic              upsp_ac_wlast;
    logic              upsp_ac_wvalid;
    logic              ac_upsp_wready = 1'b0;
`ifdef UPSP_PACK_STAT_EN
    logic [31:0]       stat_beats;
    logic [31:0]       stat_stalls;
`endif

    int checks = 0;
    int errors = 0;
    int wr_mode = 1;          // 0: wready low, 1: wready high, 2: random
    int n_hs = 0;
    int n_stall = 0;
    beat_t            exp_q[$];
    logic [PIX_W-1:0] pend[$];

    upsp_wdata_packer #(
        .PIX_W        (PIX_W),
        .PIX_PER_BEAT (PPB),
        .LINE_PIX     (LINE_PIX),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_pix_data    (in_pix_data),
        .in_pix_valid   (in_pix_valid),
        .in_pix_ready   (in_pix_ready),
        .upsp_ac_wdata  (upsp_ac_wdata),
        .upsp_ac_wstrb  (upsp_ac_wstrb),
        .upsp_ac_wlast  (upsp_ac_wlast),
        .upsp_ac_wvalid (upsp_ac_wvalid),
        .ac_upsp_wready (ac_upsp_wready)
`ifdef UPSP_PACK_STAT_EN
        ,
        .stat_beats     (stat_beats),
        .stat_stalls    (stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // a line is a flat list of pixels; beats are consecutive PPB-sized chunks of it
    task automatic new_line(input bit seq);
        logic [PIX_W-1:0] line [LINE_PIX];
        beat_t e;
        for (int i = 0; i < LINE_PIX; i++)
            line[i] = seq ? PIX_W'(i + 1) : PIX_W'($urandom);
        for (int b = 0; b * PPB < LINE_PIX; b++) begin
            e = '0;
            for (int l = 0; l < PPB; l++) begin
                if (b * PPB + l < LINE_PIX) begin
                    e.data[l*PIX_W +: PIX_W] = line[b*PPB + l];
                    e.strb[l] = 1'b1;
                end
            end
            e.last = ((b + 1) * PPB >= LINE_PIX);
            exp_q.push_back(e);
        end
        for (int i = 0; i < LINE_PIX; i++) pend.push_back(line[i]);
    endtask

    // present one pixel after 'gap' idle cycles; 'waited' counts cycles refused
    task automatic send_one(input int gap, output int waited);
        int budget;
        budget = 500;
        waited = 0;
        if (pend.size() == 0) new_line(1'b0);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_pix_valid = 1'b1;
        in_pix_data  = pend[0];
        while (!in_pix_ready && budget > 0) begin
            @(negedge clk);
            budget--;
            waited++;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL pixel_accept_timeout got=ready_low exp=ready_high");
            pend.delete();
        end else begin
            void'(pend.pop_front());
        end
        @(posedge clk);
        #1 in_pix_valid = 1'b0;
    endtask

    task automatic finish_line();
        int w;
        while (pend.size() != 0) send_one(0, w);
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 2000;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        chk(name, 128'(exp_q.size()), 128'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_pix_valid = 1'b0;
        exp_q.delete();
        pend.delete();
        @(posedge clk);
        #2;
        chk("rst_ready", 128'(in_pix_ready), 128'd0);
        chk("rst_wvalid", 128'(upsp_ac_wvalid), 128'd0);
        chk("rst_wdata", 128'(upsp_ac_wdata), 128'd0);
        chk("rst_wstrb_wlast", 128'({upsp_ac_wstrb, upsp_ac_wlast}), 128'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("ready_after_rst", 128'(in_pix_ready), 128'd1);
    endtask

    // pixels accepted from column 0 with an empty FIFO before a stalled AC blocks input
    function automatic int stall_accept_limit();
        int beats;
        int col;
        beats = 0;
        for (int n = 0; n < 100000; n++) begin
            col = n % LINE_PIX;
            if ((col % PPB) == PPB - 1 || col == LINE_PIX - 1) begin
                if (beats == DEPTH) return n;
                beats++;
            end
        end
        return -1;
    endfunction

    // AC-side ready, changed just after the rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (wr_mode)
                0:       ac_upsp_wready = 1'b0;
                1:       ac_upsp_wready = 1'b1;
                default: ac_upsp_wready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // monitor: compares every handshaked beat and checks hold while stalled
    initial begin : monitor
        beat_t got;
        beat_t held;
        beat_t e;
        bit    held_v;
        held_v = 1'b0;
        forever begin
            @(negedge clk);
            got = {upsp_ac_wlast, upsp_ac_wstrb, upsp_ac_wdata};
            if (!rst_n) begin
                held_v  = 1'b0;
                n_hs    = 0;
                n_stall = 0;
            end else begin
                if (held_v) chk("hold", 128'({upsp_ac_wvalid, got}), 128'({1'b1, held}));
                held_v = 1'b0;
                if (upsp_ac_wvalid) begin
                    if (ac_upsp_wready) begin
                        n_hs++;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL beat_unexpected got=%0h exp=none", got);
                        end else begin
                            e = exp_q.pop_front();
                            chk("beat", 128'(got), 128'(e));
                        end
                    end else begin
                        n_stall++;
                        held_v = 1'b1;
                        held   = got;
                    end
                end
            end
        end
    end

    initial begin : main
        int w;
        int wsum;
        int accepted;
        int limit;

        do_reset();

        // two counting-pattern lines back to back at full rate
        wr_mode = 1;
        wsum = 0;
        new_line(1'b1);
        new_line(1'b1);
        while (pend.size() != 0) begin
            send_one(0, w);
            wsum += w;
        end
        chk("full_rate_no_stall", 128'(wsum), 128'd0);
        drain("drain_seq");

        // random data with random input gaps and random AC ready
        wr_mode = 2;
        for (int ln = 0; ln < 20; ln++) begin
            new_line(1'b0);
            while (pend.size() != 0) send_one(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, w);
        end
        wr_mode = 1;
        drain("drain_random");

        // AC stalled with continuous input: FIFO fills, then assembly, then ready drops
        do_reset();
        wr_mode = 0;
        @(posedge clk);
        #2;
        accepted = 0;
        limit = stall_accept_limit();
        for (int c = 0; c < 40; c++) begin
            if (pend.size() == 0) new_line(1'b0);
            @(negedge clk);
            in_pix_valid = 1'b1;
            in_pix_data  = pend[0];
            if (in_pix_ready) begin
                accepted++;
                void'(pend.pop_front());
            end
        end
        @(posedge clk);
        #1 in_pix_valid = 1'b0;
        chk("stall_accepted", 128'(accepted), 128'(limit));
        chk("stall_ready_low", 128'(in_pix_ready), 128'd0);
        chk("stall_wvalid", 128'(upsp_ac_wvalid), 128'd1);
        wr_mode = 1;
        finish_line();
        drain("drain_stall");
`ifdef UPSP_PACK_STAT_EN
        @(posedge clk);
        #2;
        chk("stat_beats", 128'(stat_beats), 128'(n_hs));
        chk("stat_stalls", 128'(stat_stalls), 128'(n_stall));
`endif

        // reset with one beat queued and three pixels assembled
        wr_mode = 0;
        for (int i = 0; i < PPB + 3; i++) send_one(0, w);
        do_reset();
        wr_mode = 1;
        new_line(1'b1);
        finish_line();
        new_line(1'b0);
        finish_line();
        drain("drain_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // global guard so the bench always ends
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
